lc3_mem_ctrl: RTL and testbench
===============================

# lc3_mem_ctrl

Parametrised LC-3 main-memory controller with wait states and a ready handshake. It replaces the zero-latency RAM wrapper with a synchronous on-chip array behind an IDLE/WAIT/DONE state machine. The block asserts ready `R` for exactly one cycle per access, matching the LC-3 MEM.EN / R.W / R protocol. It sits between the LC-3 datapath (MAR/MDR) and the memory array; the CPU control FSM holds in its memory states until `R` is seen.

## Interface
- `DATA_W`, 16: word width.
- `ADDR_W`, 16: address bus width.
- `DEPTH_LOG2`, 12: the array holds 2**DEPTH_LOG2 words. Range 1..ADDR_W.
- `WAIT_CYCLES`, 2: extra wait states per access. Range 0..15.

- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ADDR` in ADDR_W: word address, sampled at request accept.
- `DATAin` in DATA_W: write data, sampled at request accept.
- `R_W` in 1: 1 = write, 0 = read, sampled at request accept.
- `MEM_EN` in 1: access request.
- `MEMout` out DATA_W: registered read data.
- `R` out 1: ready, one-cycle pulse marking access completion.
- `busy` out 1: high while an access is in flight (WAIT or DONE).
- `parity_err` out 1: parity error flag. Exists only with LC3_MEM_PARITY_EN.
- `inj_par` in 1: parity error injection. Exists only with LC3_MEM_PARITY_EN.

## Operation
- States: IDLE, WAIT, DONE. Down-counter `cnt` is 4 bits wide.
- **IDLE**
  - `MEM_EN`=1 at an edge: latch `ADDR`, `DATAin` and `R_W`, load `cnt`=WAIT_CYCLES, go to WAIT.
  - `MEM_EN`=0: stay in IDLE.
- **WAIT**
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`=0: perform the access at this edge and go to DONE.
    - Write: array[latched addr] ← latched data.
    - Read: `MEMout` ← array[latched addr].
- **DONE**
  - `R`=1 for this cycle only.
  - Next edge: go to IDLE unconditionally.
- Live inputs are ignored outside IDLE. A request that holds `MEM_EN` high through DONE is accepted again as a new access on the first IDLE edge. The CPU drops `MEM_EN` in the cycle it sees `R`.
- Out-of-range address: any latched address bit at or above DEPTH_LOG2 is nonzero.
  - Write: dropped.
  - Read: returns 0.
  - Handshake timing is identical to an in-range access.
- `MEMout` holds its value through writes and idle time. It changes only on a read completion or reset.
- Array contents are not reset and power up undefined.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `R`=0, `busy`=0, `MEMout`=0, `cnt`=0, `parity_err`=0.
- Latency: request sampled at edge N → access committed at edge N+WAIT_CYCLES+1 → `R` high in the cycle after that edge.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- `rst` asserted mid-access: returns to IDLE immediately and `R` never pulses.
  - A write not yet committed is lost, and the array is unchanged.
  - A write already committed (state DONE) remains in the array.
- Read and write to the same address in consecutive accesses: the read returns the newly written data (no bypass needed, accesses are serialised).

## Configuration
- Macro `LC3_MEM_PARITY_EN`.
- **Defined**
  - The array is DATA_W+1 bits wide and stores the even-parity bit of the data on every write.
  - `inj_par`=1 at request accept of a write causes the stored parity bit to be inverted.
  - On a read, `parity_err` is set with `R` when the recomputed parity ≠ the stored bit, and holds until the next read completion or reset.
  - Out-of-range reads report `parity_err`=0.
- **Undefined**: the `parity_err` and `inj_par` ports and the extra array bit are absent; all other behaviour is identical.

## Test plan
- **Reset:** drive `rst`=1 with random inputs → `R`=0, `busy`=0, `MEMout`=0x0000.
- **Basic write/read, WAIT_CYCLES=2:** write 0xBEEF to 0x0123, then read 0x0123.
  - `R` pulses exactly 3 cycles after each accept edge.
  - `MEMout`=0xBEEF and `busy` is high for 4 cycles per access.
- **WAIT_CYCLES=0, DEPTH_LOG2=4:** write 0x1234 to 0x0010 (out of range), then read 0x0010 and 0x0000.
  - Both reads return 0x0000 (0x0000 was pre-written with 0).
  - `R` arrives 1 cycle after accept.
- **Held MEM_EN:** keep `MEM_EN`=1 for 12 cycles with WAIT_CYCLES=1 → exactly 3 `R` pulses, spaced 4 cycles apart.
- **Reset mid-write:** write 0xAAAA to 0x0005 over old data 0x5555, pulse `rst` during WAIT, then read 0x0005.
  - The read returns 0x5555.
  - No `R` pulse occurs for the aborted write.
- **Parity (macro defined):** write 0x00FF with `inj_par`=1, then read it → `parity_err`=1 with `R`; a subsequent clean read of another word → `parity_err`=0.

Source files
------------

// File: rtl/lc3_mem_ctrl.sv
// LC-3 main-memory controller: synchronous on-chip array behind an IDLE/WAIT/DONE ready handshake.
// Define LC3_MEM_PARITY_EN to add a stored even-parity bit, injection input and error flag.
module lc3_mem_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH_LOG2  = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATAin,
    input  logic              R_W,
    input  logic              MEM_EN,
`ifdef LC3_MEM_PARITY_EN
    input  logic              inj_par,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] MEMout,
    output logic              R,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
`ifdef LC3_MEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept;
    logic                  commit;
    logic                  in_range;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  rw_q;
    logic [DATA_W-1:0]     memout_q;
    logic [DEPTH_LOG2-1:0] idx;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     rd_word;
    logic [WORD_W-1:0]     mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MEM_EN) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are captured only on accept; live inputs are ignored while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
        end else if (accept) begin
            addr_q <= ADDR;
            data_q <= DATAin;
            rw_q   <= R_W;
        end
    end

    assign idx      = addr_q[DEPTH_LOG2-1:0];
    assign in_range = (addr_q >> DEPTH_LOG2) == '0;
    assign rd_word  = mem[idx];

`ifdef LC3_MEM_PARITY_EN
    logic inj_q;
    logic perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_q <= 1'b0;
        end else if (accept) begin
            inj_q <= inj_par;
        end
    end

    // Even parity: stored bit makes the total count of ones even; injection flips it.
    assign wr_word = {(^data_q) ^ inj_q, data_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (commit && !rw_q) begin
            perr_q <= in_range && ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
        end
    end

    assign parity_err = perr_q;
`else
    assign wr_word = data_q;
`endif

    // Array has no reset; commit is derived from the async-reset state, so reset blocks writes.
    always_ff @(posedge clk) begin
        if (commit && rw_q && in_range) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memout_q <= '0;
        end else if (commit && !rw_q) begin
            memout_q <= in_range ? rd_word[DATA_W-1:0] : '0;
        end
    end

    assign MEMout = memout_q;
    assign R      = (state_q == StDone);
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: three differently parameterised instances checked every
// cycle against a timestamp-based transaction model, plus directed literal expectations.
module tb_lc3_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] addr   [3];
    logic [15:0] din    [3];
    logic [15:0] memout [3];
    logic        rw     [3];
    logic        mem_en [3];
    logic        inj    [3];
    logic        r      [3];
    logic        busy   [3];
    logic        perr   [3];

    int tests = 0;
    int fails = 0;

    // Lane 0: WAIT=2/DEPTH_LOG2=12, lane 1: WAIT=0/DEPTH_LOG2=4, lane 2: WAIT=1/DEPTH_LOG2=12.
    function automatic int wc(input int ln);
        return (ln == 0) ? 2 : ((ln == 1) ? 0 : 1);
    endfunction

    function automatic int dl(input int ln);
        return (ln == 1) ? 4 : 12;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lane
        lc3_mem_ctrl #(
            .DATA_W     (16),
            .ADDR_W     (16),
            .DEPTH_LOG2 ((g == 1) ? 4 : 12),
            .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 1))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ADDR      (addr[g]),
            .DATAin    (din[g]),
            .R_W       (rw[g]),
            .MEM_EN    (mem_en[g]),
`ifdef LC3_MEM_PARITY_EN
            .inj_par   (inj[g]),
            .parity_err(perr[g]),
`endif
            .MEMout    (memout[g]),
            .R         (r[g]),
            .busy      (busy[g])
        );
`ifndef LC3_MEM_PARITY_EN
        assign perr[g] = 1'b0;
`endif
    end

    task automatic chk(input string name, input int ln, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lane%0d: got %h, expected %h at %0t", name, ln, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction timestamps) ----------------
    int          ecount = 0;
    int          free_e [3] = '{0, 0, 0};
    int          done_e [3] = '{-1, -1, -1};
    logic [15:0] l_addr [3];
    logic [15:0] l_data [3];
    logic        l_rw   [3];
    logic        l_inj  [3];
    logic [15:0] mem_m  [int];
    logic        bad_m  [int];
    logic        exp_r    [3] = '{1'b0, 1'b0, 1'b0};
    logic        exp_busy [3] = '{1'b0, 1'b0, 1'b0};
    logic        exp_perr [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] exp_out  [3] = '{16'h0, 16'h0, 16'h0};

    task automatic model_commit(input int ln);
        int key;
        bit ok;
        key = ln * 65536 + int'(l_addr[ln]);
        ok  = (int'(l_addr[ln]) >> dl(ln)) == 0;
        if (l_rw[ln]) begin
            if (ok) begin
                mem_m[key] = l_data[ln];
                bad_m[key] = l_inj[ln];
            end
        end else if (!ok) begin
            exp_out[ln]  = 16'h0000;
            exp_perr[ln] = 1'b0;
        end else if (mem_m.exists(key)) begin
            exp_out[ln]  = mem_m[key];
            exp_perr[ln] = bad_m[key];
        end else begin
            exp_out[ln]  = 'x;
            exp_perr[ln] = 1'bx;
        end
    endtask

    always @(posedge clk) begin
        ecount++;
        for (int ln = 0; ln < 3; ln++) begin
            if (rst) begin
                free_e[ln]   = 0;
                done_e[ln]   = -1;
                exp_r[ln]    = 1'b0;
                exp_busy[ln] = 1'b0;
                exp_out[ln]  = 16'h0000;
                exp_perr[ln] = 1'b0;
            end else begin
                // Accepted once the previous access (W+3 cycles) has fully retired.
                if (ecount >= free_e[ln] && mem_en[ln] === 1'b1) begin
                    l_addr[ln] = addr[ln];
                    l_data[ln] = din[ln];
                    l_rw[ln]   = rw[ln];
                    l_inj[ln]  = inj[ln];
                    done_e[ln] = ecount + wc(ln) + 1;
                    free_e[ln] = ecount + wc(ln) + 3;
                end
                if (ecount == done_e[ln]) model_commit(ln);
                exp_r[ln]    = (ecount == done_e[ln]);
                exp_busy[ln] = (ecount <= free_e[ln] - 2);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        for (int ln = 0; ln < 3; ln++) begin
            chk("cyc_R", ln, 16'(r[ln]), 16'(exp_r[ln]));
            chk("cyc_busy", ln, 16'(busy[ln]), 16'(exp_busy[ln]));
            if (!$isunknown(exp_out[ln])) chk("cyc_MEMout", ln, memout[ln], exp_out[ln]);
`ifdef LC3_MEM_PARITY_EN
            if (!$isunknown(exp_perr[ln])) chk("cyc_perr", ln, 16'(perr[ln]), 16'(exp_perr[ln]));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    // Called at a negedge with the lane idle; returns latency, busy count and data seen with R.
    task automatic access(input int ln, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic ij,
                          output int lat, output int bc, output logic [15:0] q, output logic pe);
        mem_en[ln] = 1'b1;
        rw[ln]     = w;
        addr[ln]   = a;
        din[ln]    = d;
        inj[ln]    = ij;
        @(posedge clk);
        #1;
        mem_en[ln] = 1'b0;
        lat = 0;
        bc  = (busy[ln] === 1'b1) ? 1 : 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy[ln] === 1'b1) bc++;
        end while (r[ln] !== 1'b1 && lat < 40);
        q  = memout[ln];
        pe = perr[ln];
        tests++;
        if (r[ln] !== 1'b1) begin
            fails++;
            $display("FAIL ready_timeout lane%0d: got no R, expected R within 40 cycles", ln);
        end
        @(posedge clk);
        #1;
        if (busy[ln] === 1'b1) bc++;
        @(negedge clk);
    endtask

    function automatic logic [15:0] oor(input int ln);
        if (ln == 1) return 16'($urandom_range(16, 65535));
        return {4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095))};
    endfunction

    int          lat, bc, rp, np;
    int          pos [4];
    logic [15:0] q;
    logic        pe;
    logic [15:0] pool [3][8];

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got time limit, expected bench completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst = 1'b1;
        for (int ln = 0; ln < 3; ln++) begin
            mem_en[ln] = 1'($urandom_range(0, 1));
            rw[ln]     = 1'($urandom_range(0, 1));
            addr[ln]   = 16'($urandom);
            din[ln]    = 16'($urandom);
            inj[ln]    = 1'($urandom_range(0, 1));
        end
        repeat (3) @(negedge clk);
        for (int ln = 0; ln < 3; ln++) begin
            chk("reset_R", ln, 16'(r[ln]), 16'h0);
            chk("reset_busy", ln, 16'(busy[ln]), 16'h0);
            chk("reset_MEMout", ln, memout[ln], 16'h0000);
            mem_en[ln] = 1'b0;
            inj[ln]    = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic write/read, WAIT_CYCLES=2.
        access(0, 1'b1, 16'h0123, 16'hBEEF, 1'b0, lat, bc, q, pe);
        chk("wr_latency", 0, 16'(lat), 16'd3);
        chk("wr_busy_cycles", 0, 16'(bc), 16'd4);
        access(0, 1'b0, 16'h0123, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("rd_latency", 0, 16'(lat), 16'd3);
        chk("rd_busy_cycles", 0, 16'(bc), 16'd4);
        chk("rd_data", 0, q, 16'hBEEF);

        // WAIT_CYCLES=0, DEPTH_LOG2=4: out-of-range write dropped, out-of-range read returns 0.
        access(1, 1'b1, 16'h0000, 16'h7777, 1'b0, lat, bc, q, pe);
        chk("w0_latency", 1, 16'(lat), 16'd1);
        access(1, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("w0_rd_data", 1, q, 16'h7777);
        access(1, 1'b1, 16'h0000, 16'h0000, 1'b0, lat, bc, q, pe);
        access(1, 1'b1, 16'h0010, 16'h1234, 1'b0, lat, bc, q, pe);
        access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("oor_rd_data", 1, q, 16'h0000);
        chk("oor_latency", 1, 16'(lat), 16'd1);
        access(1, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("no_alias_rd", 1, q, 16'h0000);

        // Held MEM_EN for 12 cycles, WAIT_CYCLES=1.
        access(2, 1'b1, 16'h0042, 16'h1357, 1'b0, lat, bc, q, pe);
        chk("w1_latency", 2, 16'(lat), 16'd2);
        mem_en[2] = 1'b1;
        rw[2]     = 1'b0;
        addr[2]   = 16'h0042;
        np = 0;
        for (int i = 0; i < 4; i++) pos[i] = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (r[2] === 1'b1 && np < 4) begin
                pos[np] = i;
                np++;
            end
        end
        mem_en[2] = 1'b0;
        @(negedge clk);
        chk("held_pulses", 2, 16'(np), 16'd3);
        chk("held_first", 2, 16'(pos[0]), 16'd3);
        chk("held_space1", 2, 16'(pos[1] - pos[0]), 16'd4);
        chk("held_space2", 2, 16'(pos[2] - pos[1]), 16'd4);
        chk("held_data", 2, memout[2], 16'h1357);

        // Reset during WAIT aborts an uncommitted write.
        access(0, 1'b1, 16'h0005, 16'h5555, 1'b0, lat, bc, q, pe);
        mem_en[0] = 1'b1;
        rw[0]     = 1'b1;
        addr[0]   = 16'h0005;
        din[0]    = 16'hAAAA;
        @(posedge clk);
        #1;
        mem_en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rp = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (r[0] === 1'b1) rp++;
        end
        @(negedge clk);
        chk("abort_no_R", 0, 16'(rp), 16'd0);
        access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("abort_rd_data", 0, q, 16'h5555);

`ifdef LC3_MEM_PARITY_EN
        access(0, 1'b1, 16'h0200, 16'h00FF, 1'b1, lat, bc, q, pe);
        access(0, 1'b1, 16'h0201, 16'h0F0F, 1'b0, lat, bc, q, pe);
        access(0, 1'b0, 16'h0200, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("par_inj_err", 0, 16'(pe), 16'h1);
        chk("par_inj_data", 0, q, 16'h00FF);
        access(0, 1'b0, 16'h0201, 16'h0000, 1'b0, lat, bc, q, pe);
        chk("par_clean", 0, 16'(pe), 16'h0);
`endif

        // Random phase: initialise an address pool per lane, then free-running random traffic.
        for (int ln = 0; ln < 3; ln++) begin
            for (int k = 0; k < 8; k++) begin
                pool[ln][k] = (ln == 1) ? 16'($urandom_range(0, 15))
                                        : 16'($urandom_range(0, 4095));
                access(ln, 1'b1, pool[ln][k], 16'($urandom), 1'($urandom_range(0, 1)),
                       lat, bc, q, pe);
            end
        end
        repeat (3000) begin
            for (int ln = 0; ln < 3; ln++) begin
                mem_en[ln] = ($urandom_range(0, 3) != 0);
                rw[ln]     = 1'($urandom_range(0, 1));
                din[ln]    = 16'($urandom);
                inj[ln]    = ($urandom_range(0, 3) == 0);
                addr[ln]   = ($urandom_range(0, 7) == 0) ? oor(ln)
                                                         : pool[ln][$urandom_range(0, 7)];
            end
            @(negedge clk);
        end
        for (int ln = 0; ln < 3; ln++) mem_en[ln] = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
